// File: rtl/alu_exec_unit.sv
// alu_exec_unit: latches an ALU opcode and operands on start_i, then computes
// the result with a start/busy/done handshake. Single-cycle ops take one
// EXEC cycle. An optional iterative shift-add multiplier is controlled by the
// macro ALU_EXEC_MULT_EN; when the macro is undefined, opcode 4'b0111 is
// treated as illegal.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  illegal_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;

`ifdef ALU_EXEC_MULT_EN
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam int         CW     = $clog2(DATA_WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ill;
`ifdef ALU_EXEC_MULT_EN
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] acc_nxt;
`endif

  // Single-cycle datapath on the latched opcode/operands
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_LUI:  alu_res = {b_q[15:0], {(DATA_WIDTH-16){1'b0}}};
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state, operand latching and completion write-back
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MULT_EN
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_nxt   = b_q[0] ? (acc_q + a_q) : acc_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          op_d    = alu_operation_i;
          a_d     = a_i;
          b_d     = b_i;
          state_d = S_EXEC;
`ifdef ALU_EXEC_MULT_EN
          if (alu_operation_i == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = CW'(DATA_WIDTH);
            acc_d   = '0;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = alu_ill;
        state_d   = S_DONE;
      end
`ifdef ALU_EXEC_MULT_EN
      // One multiplier bit per cycle: a_q is the shifting multiplicand,
      // b_q the shifting multiplier; the last iteration writes back directly.
      S_MUL: begin
        acc_d = acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d  = acc_nxt;
          zero_d    = (acc_nxt == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MULT_EN
      cnt_q     <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MULT_EN
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;
  assign done_o    = (state_q == S_DONE);
`ifdef ALU_EXEC_MULT_EN
  assign busy_o    = (state_q == S_EXEC) || (state_q == S_MUL);
`else
  assign busy_o    = (state_q == S_EXEC);
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed test for alu_exec_unit. Expected results are
// queued when each op is started and compared when done_o is seen.
module tb_alu_exec_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [3:0]    alu_operation_i;
  logic [DW-1:0] a_i, b_i;
  logic [DW-1:0] result_o;
  logic          zero_o, illegal_o, busy_o, done_o;

  typedef struct packed {
    logic [DW-1:0] r;
    logic          z;
    logic          il;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc;
  int   busy_cnt;

  alu_exec_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .alu_operation_i(alu_operation_i), .a_i(a_i), .b_i(b_i),
    .result_o(result_o), .zero_o(zero_o), .illegal_o(illegal_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one operation
  function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.r  = '0;
    e.il = 1'b0;
    case (op)
      4'b0011: e.r = a + b;
      4'b0100: e.r = a - b;
      4'b0010: e.r = a | b;
      4'b0110: e.r = a & b;
      4'b0101: e.r = {b[15:0], 16'h0000};
`ifdef ALU_EXEC_MULT_EN
      4'b0111: e.r = DW'(64'(a) * 64'(b));
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start strobe and queue the expected outcome
  task automatic start_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    start_i = 1'b1; alu_operation_i = op; a_i = a; b_i = b;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Wait (bounded) for done_o, counting busy cycles, then score the result
  task automatic wait_done(input string tag, input int maxc);
    exp_t e;
    cyc = 0;
    busy_cnt = 0;
    while (done_o !== 1'b1 && cyc < maxc) begin
      if (busy_o === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done"}, DW'(done_o), DW'(1));
    chk({tag, " busy_in_done"}, DW'(busy_o), DW'(0));
    if (done_o === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " result"}, result_o, e.r);
      chk({tag, " zero"}, DW'(zero_o), DW'(e.z));
      chk({tag, " illegal"}, DW'(illegal_o), DW'(e.il));
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; alu_operation_i = '0; a_i = '0; b_i = '0;
    #1;
    chk("rst result", result_o, '0);
    chk("rst zero", DW'(zero_o), '0);
    chk("rst illegal", DW'(illegal_o), '0);
    chk("rst busy", DW'(busy_o), '0);
    chk("rst done", DW'(done_o), '0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADD 5+7, two-edge latency, single-cycle done pulse
    start_op(4'b0011, 32'd5, 32'd7);
    chk("add busy", DW'(busy_o), DW'(1));
    wait_done("add", 10);
    chk("add latency", DW'(cyc), DW'(1));
    @(negedge clk);
    chk("add done pulse", DW'(done_o), '0);
    chk("add hold", result_o, 32'd12);

    // SUB to zero, then OR started in the DONE cycle
    start_op(4'b0100, 32'd9, 32'd9);
    wait_done("sub", 10);
    start_op(4'b0010, 32'hF0, 32'h0F);
    chk("b2b gap done", DW'(done_o), '0);
    chk("b2b zero held", DW'(zero_o), DW'(1));
    wait_done("or", 10);
    chk("or latency", DW'(cyc), DW'(1));

    // LUI and AND
    start_op(4'b0101, 32'hDEAD1234, 32'h00001234);
    wait_done("lui", 10);
    start_op(4'b0110, 32'hFF00FF00, 32'h0FF00FF0);
    wait_done("and", 10);

    // Illegal decoder default, then ADD wrap
    @(negedge clk);
    start_op(4'b1001, 32'd3, 32'd4);
    wait_done("illegal", 10);
    start_op(4'b0011, 32'hFFFFFFFF, 32'd1);
    chk("status held", DW'(illegal_o), DW'(1));
    wait_done("add wrap", 10);

`ifdef ALU_EXEC_MULT_EN
    // MUL with a start pulse mid-operation that must be ignored
    @(negedge clk);
    start_op(4'b0111, 32'd1000, 32'd3000);
    cyc = 0; busy_cnt = 0;
    while (done_o !== 1'b1 && cyc < 100) begin
      if (busy_o === 1'b1) busy_cnt++;
      start_i = (cyc == 5);
      alu_operation_i = 4'b0011; a_i = 32'd1; b_i = 32'd1;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    chk("mul busy cycles", DW'(busy_cnt), DW'(32));
    begin
      exp_t e;
      chk("mul done", DW'(done_o), DW'(1));
      e = sb.pop_front();
      chk("mul result", result_o, e.r);
      chk("mul result const", result_o, 32'd3000000);
      chk("mul illegal", DW'(illegal_o), DW'(e.il));
    end
    @(negedge clk);
    chk("mul ignored start", DW'(done_o | busy_o), '0);

    // Reset in the middle of a multiply
    start_op(4'b0111, 32'd1000, 32'd3000);
    repeat (9) @(negedge clk);
    chk("mul mid busy", DW'(busy_o), DW'(1));
    reset = 1'b1;
    #1;
    chk("mid rst result", result_o, '0);
    chk("mid rst zero", DW'(zero_o), '0);
    chk("mid rst illegal", DW'(illegal_o), '0);
    chk("mid rst busy", DW'(busy_o), '0);
    chk("mid rst done", DW'(done_o), '0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) busy_cnt++;
    end
    chk("no done after rst", DW'(busy_cnt), '0);
    start_op(4'b0011, 32'd20, 32'd22);
    wait_done("post rst add", 10);
`else
    // Without the multiplier, 0111 is an illegal single-cycle op
    @(negedge clk);
    start_op(4'b0111, 32'd1000, 32'd3000);
    wait_done("mul illegal", 10);
    chk("mul illegal latency", DW'(cyc), DW'(1));
    @(negedge clk);
    chk("mul illegal pulse", DW'(done_o), '0);
`endif

    chk("scoreboard empty", DW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
